alu_mult_ctrl: RTL and testbench

Multi-cycle 32x32->64 multiply controller that sequences the shared 32-bit ALU. It handles MULT (signed) and MULTU (unsigned) using shift-and-add, with one ALU operation per cycle. It drives the ALU operand and opcode ports while busy; the datapath muxes ALU ownership on alu_own. Results go to the HI/LO registers in the datapath.

---
 rtl/cpu_types_pkg.sv | 43 ++++
 rtl/alu_mult_if.sv | 31 +++
 rtl/alu_mult_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_alu_mult_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, multiply-controller states, word helpers.
// No logic of its own; imported by the controller, its interface and benches.
// No flow control here; types only.
package cpu_types_pkg;

  localparam int WORD_W     = 32;
  localparam int MULT_ITERS = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Opcodes understood by the shared ALU; the multiplier only uses ADD/SUB/NOR.
  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;

  // Multiply sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ABS_A   = 3'd1,
    ABS_B   = 3'd2,
    ITER    = 3'd3,
    NEG_LO  = 3'd4,
    NEG_HI1 = 3'd5,
    NEG_HI2 = 3'd6,
    DONE    = 3'd7
  } multstate_t;

  // Carry out of an unsigned add, recovered from the wrapped sum alone:
  // the sum is smaller than an addend exactly when the add overflowed.
  function automatic logic add_carry(input word_t sum, input word_t addend);
    return (sum < addend);
  endfunction

endpackage

// File: rtl/alu_mult_if.sv
// Bundle between the multiply controller and the datapath that owns the ALU mux.
// No latency; wires only.
// No backpressure; the datapath must honour alu_own every cycle it is high.
interface alu_mult_if;
  import cpu_types_pkg::*;

  logic   start;
  logic   is_signed;
  word_t  opA;
  word_t  opB;
  logic   alu_own;
  aluop_t alu_op;
  word_t  alu_a;
  word_t  alu_b;
  word_t  alu_out;
  logic   busy;
  logic   done;
  word_t  hi;
  word_t  lo;

  modport controller (
    input  start, is_signed, opA, opB, alu_out,
    output alu_own, alu_op, alu_a, alu_b, busy, done, hi, lo
  );

  modport datapath (
    output start, is_signed, opA, opB, alu_out,
    input  alu_own, alu_op, alu_a, alu_b, busy, done, hi, lo
  );

endinterface

// File: rtl/alu_mult_ctrl.sv
// 32x32->64 shift-add multiplier (MULT/MULTU) sequencing the shared ALU, one op per cycle.
// Latency: done at k+33 unsigned, k+35 signed same sign, k+38 signed mixed sign.
// No backpressure: start is taken only in IDLE and silently dropped otherwise.
module alu_mult_ctrl
  import cpu_types_pkg::*;
#(
  parameter int ITERS = MULT_ITERS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        alu_own,
  output aluop_t      alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITERS);

  multstate_t state_q, state_d;

  // mcand holds |A| once the ABS phase is over; lo starts as the multiplier
  // and is shifted out as product bits shift in.
  word_t      mcand_q, mcand_d;
  word_t      hi_q, hi_d;
  word_t      lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       neg_q, neg_d;
  logic       lo_zero_q, lo_zero_d;

  logic       last_iter;
  logic       iter_carry;

  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

  // State register; reset abandons any run in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ALU request; the ALU sees ADD 0,0 whenever it is not owned.
  always_comb begin
    state_d = state_q;
    alu_op  = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = is_signed ? ABS_A : ITER;
        end
      end
      ABS_A: begin
        alu_op  = ALU_SUB;
        alu_b   = mcand_q;
        state_d = ABS_B;
      end
      ABS_B: begin
        alu_op  = ALU_SUB;
        alu_b   = lo_q;
        state_d = ITER;
      end
      ITER: begin
        alu_op = ALU_ADD;
        alu_a  = hi_q;
        alu_b  = lo_q[0] ? mcand_q : '0;
        if (last_iter) begin
          state_d = neg_q ? NEG_LO : DONE;
        end
      end
      NEG_LO: begin
        alu_op  = ALU_SUB;
        alu_b   = lo_q;
        state_d = NEG_HI1;
      end
      NEG_HI1: begin
        alu_op  = ALU_NOR;
        alu_a   = hi_q;
        alu_b   = hi_q;
        state_d = NEG_HI2;
      end
      NEG_HI2: begin
        alu_op  = ALU_ADD;
        alu_a   = hi_q;
        alu_b   = {31'b0, lo_zero_q};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values; each state writes back the single ALU result it asked for.
  always_comb begin
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    lo_zero_d  = lo_zero_q;
    iter_carry = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d   = opA;
          lo_d      = opB;
          hi_d      = '0;
          cnt_d     = '0;
          neg_d     = is_signed & (opA[31] ^ opB[31]);
          lo_zero_d = 1'b0;
        end
      end
      ABS_A: begin
        // 0x80000000 negates to itself and is then used as unsigned 2^31.
        if (mcand_q[31]) begin
          mcand_d = alu_out;
        end
      end
      ABS_B: begin
        if (lo_q[31]) begin
          lo_d = alu_out;
        end
      end
      ITER: begin
        // 33-bit partial sum shifts right one place into {hi,lo}.
        iter_carry = add_carry(alu_out, hi_q);
        hi_d       = {iter_carry, alu_out[31:1]};
        lo_d       = {alu_out[0], lo_q[31:1]};
        cnt_d      = cnt_q + 1'b1;
      end
      NEG_LO: begin
        // Low word of zero means the +1 of the two's complement ripples into hi.
        lo_d      = alu_out;
        lo_zero_d = (lo_q == '0);
      end
      NEG_HI1: begin
        hi_d = alu_out;
      end
      NEG_HI2: begin
        hi_d = alu_out;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, cleared by reset so hi/lo read zero afterwards.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      lo_zero_q <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      lo_zero_q <= lo_zero_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign alu_own = (state_q != IDLE) && (state_q != DONE);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Self-checking bench for alu_mult_ctrl with an external ALU model.
// Transaction-level reference: product by 64-bit arithmetic, timing by latency rule.
// Directed corner cases pin the reference; random runs exercise the rest.
module tb_alu_mult_ctrl;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic        is_signed;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        alu_own;
  aluop_t      alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  alu_mult_ctrl dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .is_signed (is_signed),
    .opA       (opA),
    .opB       (opB),
    .alu_own   (alu_own),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared ALU, combinational.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_NOR: alu_out = ~(alu_a | alu_b);
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;
  logic chk_en = 1'b0;

  always @(posedge CLK) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", nm, ecnt, act, exp);
    end
  endtask

  // Reference: m_cyc counts cycles since acceptance (0 = idle), m_n is the run length.
  int          m_cyc = 0;
  int          m_n   = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  function automatic int exp_latency(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (!s) return 33;
    return (a[31] ^ b[31]) ? 38 : 35;
  endfunction

  function automatic logic [63:0] exp_product(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'b0, a};
    xb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  always @(posedge CLK) begin
    logic [63:0] p;
    if (!nRST) begin
      m_cyc = 0;
      m_n   = 0;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_cyc == 0) begin
      if (start) begin
        p     = exp_product(is_signed, opA, opB);
        m_hi  = p[63:32];
        m_lo  = p[31:0];
        m_n   = exp_latency(is_signed, opA, opB);
        m_cyc = 1;
      end
    end else if (m_cyc == m_n) begin
      m_cyc = 0;
    end else begin
      m_cyc = m_cyc + 1;
    end
  end

  // Every cycle: status flags; when idle or done also the ALU request and hi/lo.
  always @(negedge CLK) begin
    logic eb, ed;
    if (chk_en) begin
      eb = (m_cyc != 0);
      ed = eb && (m_cyc == m_n);
      chk("status_busy_done_own", 96'({busy, done, alu_own}), 96'({eb, ed, eb && !ed}));
      if (!eb || ed) begin
        chk("alu_req_when_free", 96'({alu_op, alu_a, alu_b}), 96'({ALU_ADD, 64'h0}));
        chk("hilo", 96'({hi, lo}), 96'({m_hi, m_lo}));
      end
    end
  end

  // Issue one multiply from an idle cycle (called just after a rising edge).
  // Optionally pulse a spurious start at k+10 and/or while in DONE.
  task automatic do_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic spur_mid, input logic spur_done,
                         output int lat, output logic [31:0] rhi, output logic [31:0] rlo);
    int k;
    start = 1'b1; is_signed = s; opA = a; opB = b;
    @(posedge CLK); #1;
    k = ecnt;
    start = 1'b0; is_signed = $urandom_range(0, 1) == 1; opA = $urandom; opB = $urandom;
    lat = -1; rhi = '0; rlo = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (spur_mid && ecnt == k + 9) begin
        start = 1'b1; is_signed = 1'b1; opA = 32'h0000_1234; opB = 32'hFFFF_5678;
      end
      if (done) begin
        lat = ecnt - k + 1;
        rhi = hi; rlo = lo;
        if (spur_done) begin
          start = 1'b1; opA = 32'hAAAA_5555; opB = 32'h1357_9BDF;
        end
        break;
      end
    end
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a, b, ehi, elo;
    int          elat;
  } vec_t;

  vec_t vecs[7] = '{
    '{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 33},
    '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33},
    '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 38},
    '{1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, 35},
    '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 38},
    '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 35},
    '{1'b1, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 38}
  };

  logic [31:0] pool[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};

  initial begin
    int          lat, k;
    logic [31:0] rhi, rlo, a, b;
    logic        s;
    nRST = 1'b0; start = 1'b0; is_signed = 1'b0; opA = '0; opB = '0;
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    chk_en = 1'b1;
    chk("reset_status", 96'({busy, done, alu_own}), 96'(3'b000));
    chk("reset_alu_req", 96'({alu_op, alu_a, alu_b}), 96'({ALU_ADD, 64'h0}));
    chk("reset_hilo", 96'({hi, lo}), 96'(64'h0));
    @(posedge CLK); #1;

    // Directed corners with hand-computed products and latencies.
    foreach (vecs[i]) begin
      do_mult(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, 1'b0, lat, rhi, rlo);
      chk($sformatf("dir%0d_latency", i), 96'(lat), 96'(vecs[i].elat));
      chk($sformatf("dir%0d_product", i), 96'({rhi, rlo}), 96'({vecs[i].ehi, vecs[i].elo}));
    end

    // Starts during a run and in DONE are ignored.
    do_mult(1'b0, 32'd7, 32'd9, 1'b1, 1'b1, lat, rhi, rlo);
    chk("spur_latency", 96'(lat), 96'(33));
    chk("spur_product", 96'({rhi, rlo}), 96'(64'h3F));
    repeat (2) @(posedge CLK);
    #1;
    chk("spur_hold_hilo", 96'({hi, lo}), 96'(64'h3F));

    // Reset in the middle of a run, then a clean run.
    start = 1'b1; is_signed = 1'b1; opA = 32'hFFFF_DEAD; opB = 32'h0000_BEEF;
    @(posedge CLK); #1;
    k = ecnt;
    start = 1'b0;
    while (ecnt < k + 11) begin
      @(posedge CLK); #1;
    end
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    chk("midrst_status", 96'({busy, done, alu_own}), 96'(3'b000));
    chk("midrst_hilo", 96'({hi, lo}), 96'(64'h0));
    do_mult(1'b0, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, lat, rhi, rlo);
    chk("after_rst_latency", 96'(lat), 96'(33));
    chk("after_rst_product", 96'({rhi, rlo}), 96'(64'h0000_0000_FFFF_FFFF));

    // Randomized runs; the per-cycle reference covers timing and results.
    for (int n = 0; n < 150; n++) begin
      s = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      do_mult(s, a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, lat, rhi, rlo);
      chk("rand_latency", 96'(lat), 96'(exp_latency(s, a, b)));
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish within 1000000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
